// File: rtl/bch_bm_solver.sv
`default_nettype none
// ============================================================================
// Module      : bch_bm_solver
// Description : Inversionless Berlekamp-Massey error-locator solver for binary
//               BCH codes over GF(2^6), GF(2^8) and GF(2^10).
//               Optional macro BCH_BM_FAIL_CHECK_EN adds a locator degree check.
// Revision    : 1.0
// ============================================================================
module bch_bm_solver #(
  parameter int T_MAX = 4,
  parameter int M_MAX = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [3:0]                   t,
  input  logic [3:0]                   m,
  input  logic [2*T_MAX*M_MAX-1:0]     syndromes,
  output logic                         busy,
  output logic                         done,
  output logic [(T_MAX+1)*M_MAX-1:0]   lambda,
  output logic [2:0]                   deg,
  output logic                         fail
);

  localparam int NS = 2 * T_MAX;
  localparam int NL = T_MAX + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELTA  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_M6   = 2'd1;
  localparam logic [1:0] F_M8   = 2'd2;
  localparam logic [1:0] F_M10  = 2'd3;

  localparam logic [M_MAX-1:0] MASK6  = M_MAX'((1 << 6) - 1);
  localparam logic [M_MAX-1:0] MASK8  = M_MAX'((1 << 8) - 1);
  localparam logic [M_MAX-1:0] MASK10 = M_MAX'((1 << 10) - 1);
  localparam logic [M_MAX-1:0] POLY6  = M_MAX'(6'h03);
  localparam logic [M_MAX-1:0] POLY8  = M_MAX'(8'h1D);
  localparam logic [M_MAX-1:0] POLY10 = M_MAX'(10'h009);
  localparam logic [M_MAX-1:0] ONE    = M_MAX'(1);

  function automatic logic [M_MAX-1:0] gf_xtime(input logic [M_MAX-1:0] p,
                                                 input logic [1:0]       fsel);
    logic [M_MAX:0]   s;
    logic [M_MAX-1:0] res;
    s = {p, 1'b0};
    case (fsel)
      F_M6:    res = (s[M_MAX-1:0] & MASK6)  ^ (s[6]  ? POLY6  : '0);
      F_M8:    res = (s[M_MAX-1:0] & MASK8)  ^ (s[8]  ? POLY8  : '0);
      F_M10:   res = (s[M_MAX-1:0] & MASK10) ^ (s[10] ? POLY10 : '0);
      default: res = s[M_MAX-1:0];
    endcase
    return res;
  endfunction

  function automatic logic [M_MAX-1:0] gf_mul(input logic [M_MAX-1:0] a,
                                               input logic [M_MAX-1:0] b,
                                               input logic [1:0]       fsel);
    logic [M_MAX-1:0] acc;
    logic [M_MAX-1:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < M_MAX; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p, fsel);
    end
    return acc;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [M_MAX-1:0] syn_q    [NS];
  logic [M_MAX-1:0] syn_d    [NS];
  logic [M_MAX-1:0] lambda_q [NL];
  logic [M_MAX-1:0] lambda_d [NL];
  logic [M_MAX-1:0] b_q      [NL];
  logic [M_MAX-1:0] b_d      [NL];
  logic [M_MAX-1:0] gamma_q, gamma_d;
  logic [M_MAX-1:0] delta_q, delta_d;
  logic [2:0]       l_q, l_d;
  logic [3:0]       r_q, r_d;
  logic [3:0]       t_q, t_d;
  logic [1:0]       fsel_q, fsel_d;
  logic             fail_q, fail_d;

  logic [M_MAX-1:0] delta_w;
  logic [M_MAX-1:0] m_mask;
  logic [3:0]       t_eff;
  logic [1:0]       fsel_in;
  logic             chk_w;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = (t_eff == 4'd0) ? ST_FINISH : ST_DELTA;
      ST_DELTA:  state_d = ST_UPDATE;
      ST_UPDATE: state_d = ((r_q + 4'd1) < t_q) ? ST_DELTA : ST_FINISH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_FINISH);
  end

  always_comb begin
    t_eff = (int'(t) > T_MAX) ? 4'(T_MAX) : t;
    for (int i = 0; i < M_MAX; i++) m_mask[i] = (i < int'(m));
    case (m)
      4'd6:    fsel_in = F_M6;
      4'd8:    fsel_in = F_M8;
      4'd10:   fsel_in = F_M10;
      default: fsel_in = F_NONE;
    endcase
  end

  // Discrepancy: sum of lambda_j * S_(2r+1-j), terms with index <= 0 dropped
  always_comb begin
    delta_w = '0;
    for (int j = 0; j < NL; j++) begin
      int k;
      k = 2 * int'(r_q) + 1 - j;
      if (k >= 1 && k <= NS) delta_w = delta_w ^ gf_mul(lambda_q[j], syn_q[k-1], fsel_q);
    end
  end

  always_comb begin
    syn_d    = syn_q;
    lambda_d = lambda_q;
    b_d      = b_q;
    gamma_d  = gamma_q;
    delta_d  = delta_q;
    l_d      = l_q;
    r_d      = r_q;
    t_d      = t_q;
    fsel_d   = fsel_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < NS; i++) syn_d[i] = syndromes[(i+1)*M_MAX-1 -: M_MAX] & m_mask;
          for (int j = 0; j < NL; j++) begin
            lambda_d[j] = (j == 0) ? ONE : '0;
            b_d[j]      = (j == 0) ? ONE : '0;
          end
          gamma_d = ONE;
          delta_d = '0;
          l_d     = 3'd0;
          r_d     = 4'd0;
          t_d     = t_eff;
          fsel_d  = fsel_in;
        end
      end
      ST_DELTA: delta_d = delta_w;
      ST_UPDATE: begin
        r_d = r_q + 4'd1;
        // Unsupported fields leave the locator at 1 so the fixed result falls out naturally
        if (fsel_q != F_NONE) begin
          lambda_d[0] = gf_mul(gamma_q, lambda_q[0], fsel_q);
          for (int j = 1; j < NL; j++)
            lambda_d[j] = gf_mul(gamma_q, lambda_q[j], fsel_q) ^ gf_mul(delta_q, b_q[j-1], fsel_q);
          if (delta_q != '0 && {1'b0, l_q} <= r_q) begin
            b_d[0] = '0;
            for (int j = 1; j < NL; j++) b_d[j] = lambda_q[j-1];
            gamma_d = delta_q;
            l_d     = 3'({r_q, 1'b1} - {2'b00, l_q});
          end else begin
            b_d[0] = '0;
            b_d[1] = '0;
            for (int j = 2; j < NL; j++) b_d[j] = b_q[j-2];
          end
        end
      end
      default: ;
    endcase
  end

`ifdef BCH_BM_FAIL_CHECK_EN
  int hi_w;
  always_comb begin
    hi_w = 0;
    for (int j = 0; j < NL; j++) if (lambda_d[j] != '0) hi_w = j;
    chk_w = ({1'b0, l_d} > t_d) || (hi_w != int'(l_d));
  end
`else
  assign chk_w = 1'b0;
`endif

  // The fail flag is resolved on entry to FINISH from the final locator values
  always_comb begin
    fail_d = fail_q;
    if (state_q == ST_IDLE && start) fail_d = 1'b0;
    if (state_d == ST_FINISH)        fail_d = (fsel_d == F_NONE) | chk_w;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NS; i++) syn_q[i] <= '0;
      for (int j = 0; j < NL; j++) begin
        lambda_q[j] <= (j == 0) ? ONE : '0;
        b_q[j]      <= '0;
      end
      gamma_q <= '0;
      delta_q <= '0;
      l_q     <= 3'd0;
      r_q     <= 4'd0;
      t_q     <= 4'd0;
      fsel_q  <= F_NONE;
      fail_q  <= 1'b0;
    end else begin
      syn_q    <= syn_d;
      lambda_q <= lambda_d;
      b_q      <= b_d;
      gamma_q  <= gamma_d;
      delta_q  <= delta_d;
      l_q      <= l_d;
      r_q      <= r_d;
      t_q      <= t_d;
      fsel_q   <= fsel_d;
      fail_q   <= fail_d;
    end
  end

  generate
    for (genvar j = 0; j < NL; j++) begin : g_lambda
      assign lambda[(j+1)*M_MAX-1 -: M_MAX] = lambda_q[j];
    end
  endgenerate

  assign deg  = l_q;
  assign fail = fail_q;

endmodule
`default_nettype wire

// File: doc/bch_bm_solver.md
BCH_BM_SOLVER -- requirements
Module: bch_bm_solver

Interface
REQ-001 SHALL have parameter T_MAX, default 4, meaning maximum correctable errors.
REQ-002 SHALL have parameter M_MAX, default 10, meaning GF(2^m) element storage width.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request; syndromes, t and m are sampled on it.
REQ-006 SHALL have port t  input  4  correction capability for this codeword.
REQ-007 SHALL have port m  input  4  field degree.
REQ-008 SHALL have port syndromes  input  2*T_MAX*M_MAX  S_i at bits [i*M_MAX-1 -: M_MAX], i=1..2*T_MAX, S1 in LSBs.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the results are valid.
REQ-011 SHALL have port lambda  output  (T_MAX+1)*M_MAX  error-locator coefficient lambda_j at bits [(j+1)*M_MAX-1 -: M_MAX], lambda_0 in LSBs.
REQ-012 SHALL have port deg  output  3  register L, the locator length.
REQ-013 SHALL have port fail  output  1  uncorrectable or unsupported indication.

Function
REQ-014 SHALL implement FSM states IDLE, DELTA, UPDATE and FINISH.
REQ-015 SHALL, in IDLE on start=1, latch the inputs, set Lambda=1, B=1, gamma=1, L=0, r=0, and go to DELTA; start outside IDLE SHALL be ignored.
REQ-016 SHALL treat t>T_MAX as T_MAX; t=0 SHALL go from IDLE directly to FINISH.
REQ-017 SHALL, in DELTA, compute delta = sum over j=0..T_MAX of lambda_j*S_(2r+1-j), with S_k=0 for k<=0, in one cycle.
REQ-018 SHALL, in UPDATE, set Lambda <= gamma*Lambda + delta*x*B.
REQ-019 SHALL, in UPDATE when delta!=0 and 2L<=2r, also set B <= x*Lambda_old, gamma <= delta and L <= 2r+1-L.
REQ-020 SHALL, in UPDATE otherwise, set B <= x^2*B and leave gamma and L unchanged.
REQ-021 SHALL, after UPDATE, increment r and go to DELTA if r<t, else to FINISH.
REQ-022 SHALL truncate terms beyond x^T_MAX.
REQ-023 SHALL assert done=1 for exactly one cycle in FINISH, then return to IDLE.
REQ-024 SHALL hold lambda, deg and fail stable from FINISH until the next accepted start.
REQ-025 SHALL have latency: start accepted at cycle 0, done at cycle 2t+1 (t=4 gives cycle 9; t=0 gives cycle 1).
REQ-026 SHALL perform GF multiplication modulo x^6+x+1 (m=6), x^8+x^4+x^3+x^2+1 (m=8) or x^10+x^3+1 (m=10).
REQ-027 SHALL keep element bits above m at zero.
REQ-028 SHALL, for m not in {6,8,10}, run the normal sequence and output lambda=1, deg=0, fail=1.
REQ-029 SHALL perform GF addition as bitwise XOR.

Reset
REQ-030 SHALL, while rstn=0 at a clock edge, force the FSM to IDLE.
REQ-031 SHALL, while rstn=0 at a clock edge, clear busy=0, done=0, fail=0 and deg=0.
REQ-032 SHALL, while rstn=0 at a clock edge, set lambda=1 (lambda_0=1, others 0).
REQ-033 SHALL, while rstn=0 at a clock edge, clear all internal registers.
REQ-034 SHALL, on reset mid-operation, abort the computation without a done pulse.

Configuration
REQ-035 SHALL, with macro BCH_BM_FAIL_CHECK_EN defined, set fail=1 in FINISH when L>t or the highest nonzero lambda index differs from L.
REQ-036 SHALL, without BCH_BM_FAIL_CHECK_EN, assert fail only for an unsupported m, and omit the degree-check logic.

Verification
REQ-037 SHALL test: m=10, t=4, all syndromes 0 -> done at cycle 9, lambda=1, deg=0, fail=0.
REQ-038 SHALL test: m=10, t=4, S1..S8=1 (single error at position 0) -> lambda_0=1, lambda_1=1, others 0, deg=1, fail=0.
REQ-039 SHALL test: m=6, t=2, S_j=1+alpha^j (errors at positions 0 and 1) -> deg=2, lambda proportional to (1+x)(1+alpha*x), matching the golden model bit-exactly, done at cycle 5.
REQ-040 SHALL test: m=7, t=4, any syndromes -> done at cycle 9, lambda=1, deg=0, fail=1.
REQ-041 SHALL test: start pulsed again at cycle 3 -> ignored, single done at cycle 9.
REQ-042 SHALL test: rstn=0 at cycle 4 -> no done pulse, outputs at reset values, and a subsequent start completes normally.
